// File: rtl/monitor_overlay_ctrl.sv
// Overlay sequencer for the 6502 debug monitor: arms on NMI, catches the vector
// fetch, serves the top page from monitor ROM, and hands the bus back after RTI.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_NORMAL   | user code, all accesses go to RAM
// ST_ARMED    | NMI driven, waiting for the vector fetch (bounded by timeout)
// ST_OVERLAY  | monitor running, top page mapped onto monitor ROM
// ST_EXITING  | exit requested, waiting for RTI fetch then first user opcode
module monitor_overlay_ctrl #(
   parameter logic [15:0] OVL_BASE    = 16'hFF00,
   parameter logic [15:0] NMI_VEC     = 16'hFFFA,
   parameter logic [15:0] EXIT_ADDR   = 16'hFFF8,
   parameter int          ARM_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] cpu_addr,
   input  logic        cpu_rw,
   input  logic        bus_valid,
   input  logic        sync,
   input  logic        nmi_issued,
   output logic        overlay_sel,
   output logic [7:0]  rom_addr,
   output logic        mon_active,
   output logic        arm_timeout,
   output logic [7:0]  entry_count
);

   localparam int AW = $clog2(ARM_TIMEOUT) + 1;
   localparam logic [15:0] NMI_VEC_HI = NMI_VEC + 16'd1;
   localparam logic [AW-1:0] ARM_LAST = AW'(ARM_TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_NORMAL   = 2'd0,
      ST_ARMED    = 2'd1,
      ST_OVERLAY  = 2'd2,
      ST_EXITING  = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] arm_cnt_q, arm_cnt_d;
   logic [1:0]    sync_cnt_q, sync_cnt_d;
   logic          arm_timeout_q, arm_timeout_d;
   logic [7:0]    entry_count_q, entry_count_d;
   logic          mon_active_q, mon_active_d;

   logic vec_rd, exit_wr, in_window, second_sync;

   always_comb begin
      vec_rd      = cpu_rw && (cpu_addr == NMI_VEC);
      exit_wr     = !cpu_rw && (cpu_addr == EXIT_ADDR);
      in_window   = cpu_addr >= OVL_BASE;
      second_sync = bus_valid && sync && (sync_cnt_q != 2'd0);
   end

   always_comb begin
      state_d       = state_q;
      arm_cnt_d     = arm_cnt_q;
      sync_cnt_d    = sync_cnt_q;
      arm_timeout_d = arm_timeout_q;
      entry_count_d = entry_count_q;
      case (state_q)
         ST_NORMAL: begin
            // a bus cycle coinciding with the arming pulse is the first counted cycle
            if (nmi_issued) begin
               state_d       = ST_ARMED;
               arm_timeout_d = 1'b0;
               arm_cnt_d     = bus_valid ? AW'(1) : '0;
            end
         end
         ST_ARMED: begin
            if (bus_valid) begin
               if (vec_rd) begin
                  state_d       = ST_OVERLAY;
                  entry_count_d = entry_count_q + 8'd1;
               end else if (arm_cnt_q == ARM_LAST) begin
                  state_d       = ST_NORMAL;
                  arm_timeout_d = 1'b1;
               end else begin
                  arm_cnt_d = arm_cnt_q + AW'(1);
               end
            end
         end
         ST_OVERLAY: begin
            if (bus_valid && exit_wr) begin
               state_d    = ST_EXITING;
               sync_cnt_d = 2'd0;
            end
         end
         ST_EXITING: begin
            if (bus_valid && sync) begin
               if (sync_cnt_q != 2'd3) sync_cnt_d = sync_cnt_q + 2'd1;
               if (sync_cnt_q != 2'd0) state_d = ST_NORMAL;
            end
         end
         default: state_d = ST_NORMAL;
      endcase
      mon_active_d = (state_d == ST_OVERLAY) || (state_d == ST_EXITING);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_NORMAL;
         arm_cnt_q     <= '0;
         sync_cnt_q    <= 2'd0;
         arm_timeout_q <= 1'b0;
         entry_count_q <= 8'd0;
         mon_active_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         arm_cnt_q     <= arm_cnt_d;
         sync_cnt_q    <= sync_cnt_d;
         arm_timeout_q <= arm_timeout_d;
         entry_count_q <= entry_count_d;
         mon_active_q  <= mon_active_d;
      end
   end

   // the first user opcode after RTI must come from RAM, so mask the window on it
   always_comb begin
      overlay_sel = 1'b0;
      case (state_q)
         ST_ARMED:   overlay_sel = cpu_rw && ((cpu_addr == NMI_VEC) || (cpu_addr == NMI_VEC_HI));
         ST_OVERLAY: overlay_sel = in_window;
         ST_EXITING: overlay_sel = in_window && !second_sync;
         default:    overlay_sel = 1'b0;
      endcase
   end

   assign rom_addr    = cpu_addr[7:0];
   assign mon_active  = mon_active_q;
   assign arm_timeout = arm_timeout_q;
   assign entry_count = entry_count_q;

endmodule
